data_write_interface: RTL and testbench
=======================================

// Module: data_write_interface
// PURPOSE
//  Stage-5 store path; the write-side counterpart of the load formatter.
//  Takes a store (byte/hword/word, byte address, raw rs2 value) and lane-aligns the data.
//  Generates byte enables and drives a req/ready handshake to data memory.
//  Splits a misaligned store into two word-aligned beats, or faults on it, and stalls the pipeline until done.
// PARAMETERS
//  ALLOW_MISALIGNED  1  1: split word-crossing stores into 2 beats; 0: raise misaligned_fault, no write
// PORTS
//  clk               in   1   clock, rising edge
//  reset             in   1   synchronous, active-high
//  store_en          in   1   store request this cycle (single-cycle; pipeline held while store_stall)
//  long_addr         in   32  byte address of the store
//  store_value       in   32  unaligned source value (rs2)
//  store_type        in   3   one-hot, indexed by `BYTE/`HWORD/`WORD
//  store_stall       out  1   freeze upstream stages
//  store_done        out  1   1-cycle pulse: last beat accepted
//  misaligned_fault  out  1   1-cycle pulse: misaligned store rejected (ALLOW_MISALIGNED=0)
//  mem_write_req     out  1   write beat valid
//  mem_addr          out  32  word-aligned beat address (bits[1:0]=0)
//  mem_write_data    out  32  lane-aligned data; lanes with byte_en=0 driven 0
//  mem_byte_en       out  4   bit i enables lane i = data[8i+7:8i]
//  mem_ready         in   1   memory accepts beat at this edge when mem_write_req=1
// BEHAVIOUR
//  Reset: state IDLE; every output 0 on the edge after reset=1. Priority over all inputs, any state.
//  Mid-operation reset: an already-accepted beat 0 is not rolled back.
//  Type decode: BYTE > HWORD > else WORD, same priority as the load side.
//  off = long_addr[1:0]; base = {long_addr[31:2],2'b00}; split = (HWORD && off==3) || (WORD && off!=0).
//  Beat lanes, nbytes = 1/2/4:
//   - beat0 be = ((1<<nbytes)-1)<<off, truncated to 4 bits; data = value<<(8*off).
//   - beat1 (split only): be = ((1<<nbytes)-1)>>(4-off); data = value>>(8*(4-off)); addr = base+4 mod 2^32.
//  FSM IDLE -> BEAT0 -> [BEAT1] -> IDLE:
//   - IDLE, store_en=1, !split or ALLOW_MISALIGNED: register beat0/beat1 fields -> BEAT0.
//   - IDLE, store_en=1, split and !ALLOW_MISALIGNED: misaligned_fault=1 next cycle, no req, stay IDLE.
//   - BEAT0/BEAT1: mem_write_req=1; addr/data/be held stable until mem_ready=1.
//   - BEAT0 & ready & split -> BEAT1.
//   - Last beat & ready -> IDLE; store_done=1 next cycle.
//  Latency: req rises 1 cycle after store_en. Zero-wait memory gives store_done at +2 (1 beat) or +3 (split).
//  store_stall = (state!=IDLE) && !(last beat && mem_ready): combinational, so the pipeline frees on the accept edge.
//  store_en while state!=IDLE: ignored (assertion fires); cannot occur under correct stall.
//  store_en in IDLE on the cycle store_done pulses is legal (back-to-back stores).
//  mem_write_req never deasserts without mem_ready except on reset.
// STRUCTURE
//  definitions.vh: add `WORD index; typedef enum logic[1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1} store_state_t.
//  Reuse word/hword/byte types from definitions.vh.
//  Sub-module store_lane_formatter (combinational): off, type, value -> split, be0/data0, be1/data1.
//  Top holds the FSM and beat registers only.
// TESTING
//  byte @0x1003, value 0xAABBCCDD -> one beat addr 0x1000 be 1000 data 0xDD000000; store_done at +2.
//  hword @0x2006, 0x00001234 -> addr 0x2004 be 1100 data 0x12340000.
//  word @0x3001, 0x11223344, ALLOW=1 -> beat0 0x3000/1110/0x22334400; beat1 0x3004/0001/0x00000011.
//  hword @0xFFFFFFFF, 0x1234, ALLOW=1 -> beat0 0xFFFFFFFC/1000/0x34000000; beat1 0x00000000/0001/0x00000012.
//  mem_ready low 3 cycles in BEAT0 -> req/addr/data/be stable, stall=1 throughout; done 1 cycle after ready.
//  ALLOW=0: word @0x3002 -> misaligned_fault pulse, req never rises. Reset during BEAT1 -> all outputs 0, IDLE.

Source files
------------

// File: rtl/data_write_interface_pkg.sv
// Shared definitions for the store path: store-type indices, data widths and FSM states.
// Type priority (BYTE > HWORD > WORD) matches the load side.
package data_write_interface_pkg;

  localparam int BYTE  = 0;
  localparam int HWORD = 1;
  localparam int WORD  = 2;

  typedef logic [31:0] word_t;
  typedef logic [15:0] hword_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1} store_state_t;

  // Byte-lane mask of the access size, before shifting to the address offset.
  function automatic logic [3:0] size_mask(input logic [2:0] store_type);
    if (store_type[BYTE])       return 4'b0001;
    else if (store_type[HWORD]) return 4'b0011;
    else                        return 4'b1111;
  endfunction

endpackage

// File: rtl/data_write_interface_lane_formatter.sv
// Combinational lane alignment: shifts value and size mask by the byte offset
// into a 64-bit window whose low word is beat 0 and high word is beat 1.
module store_lane_formatter
  import data_write_interface_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  store_type,
  input  word_t       value,
  output logic        split,
  output logic [3:0]  be0,
  output word_t       data0,
  output logic [3:0]  be1,
  output word_t       data1
);

  logic        is_byte;
  logic        is_hword;
  logic        is_word;
  logic [3:0]  mask;
  logic [7:0]  be_wide;
  word_t       lane_mask;
  logic [63:0] data_wide;

  always_comb begin
    is_byte   = store_type[BYTE];
    is_hword  = !is_byte && store_type[HWORD];
    is_word   = !is_byte && !is_hword;
    mask      = size_mask(store_type);
    // Bytes above the access size are cleared so disabled lanes read as zero.
    lane_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    be_wide   = {4'b0000, mask} << off;
    data_wide = {32'h0, value & lane_mask} << {off, 3'b000};
    be0       = be_wide[3:0];
    be1       = be_wide[7:4];
    data0     = data_wide[31:0];
    data1     = data_wide[63:32];
    split     = (is_hword && off == 2'd3) || (is_word && off != 2'd0);
  end

endmodule

// File: rtl/data_write_interface.sv
// Stage-5 store path: registers lane-aligned beats and drives them to data memory
// over a req/ready handshake, splitting or faulting on word-crossing stores.
module data_write_interface
  import data_write_interface_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        store_en,
  input  logic [31:0] long_addr,
  input  logic [31:0] store_value,
  input  logic [2:0]  store_type,
  output logic        store_stall,
  output logic        store_done,
  output logic        misaligned_fault,
  output logic        mem_write_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_ready
);

  store_state_t state, state_next;

  logic       fmt_split;
  logic [3:0] fmt_be0, fmt_be1;
  word_t      fmt_data0, fmt_data1;
  word_t      base;

  word_t      beat0_addr, beat1_addr, beat0_data, beat1_data;
  logic [3:0] beat0_be, beat1_be;
  logic       split_q;
  logic       done_q, fault_q;
  logic       done_next, fault_next, load;
  logic       last_beat;

  assign base = {long_addr[31:2], 2'b00};

  store_lane_formatter u_fmt (
    .off        (long_addr[1:0]),
    .store_type (store_type),
    .value      (store_value),
    .split      (fmt_split),
    .be0        (fmt_be0),
    .data0      (fmt_data0),
    .be1        (fmt_be1),
    .data1      (fmt_data1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      split_q    <= 1'b0;
      beat0_addr <= '0;
      beat1_addr <= '0;
      beat0_data <= '0;
      beat1_data <= '0;
      beat0_be   <= '0;
      beat1_be   <= '0;
    end else begin
      state   <= state_next;
      done_q  <= done_next;
      fault_q <= fault_next;
      if (load) begin
        split_q    <= fmt_split;
        beat0_addr <= base;
        beat1_addr <= base + 32'd4;
        beat0_data <= fmt_data0;
        beat1_data <= fmt_data1;
        beat0_be   <= fmt_be0;
        beat1_be   <= fmt_be1;
      end
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    fault_next = 1'b0;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (store_en) begin
          if (fmt_split && !ALLOW_MISALIGNED) begin
            fault_next = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = ST_BEAT0;
          end
        end
      end
      ST_BEAT0: begin
        if (mem_ready) begin
          if (split_q) begin
            state_next = ST_BEAT1;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        if (mem_ready) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Beat fields come straight from registers, so they hold while ready is low.
  always_comb begin
    mem_write_req  = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_byte_en    = '0;
    case (state)
      ST_BEAT0: begin
        mem_write_req  = 1'b1;
        mem_addr       = beat0_addr;
        mem_write_data = beat0_data;
        mem_byte_en    = beat0_be;
      end
      ST_BEAT1: begin
        mem_write_req  = 1'b1;
        mem_addr       = beat1_addr;
        mem_write_data = beat1_data;
        mem_byte_en    = beat1_be;
      end
      default: ;
    endcase
  end

  assign last_beat        = (state == ST_BEAT1) || (state == ST_BEAT0 && !split_q);
  assign store_stall      = (state != ST_IDLE) && !(last_beat && mem_ready);
  assign store_done       = done_q;
  assign misaligned_fault = fault_q;

  no_store_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(store_en && state != ST_IDLE));

endmodule

// File: tb/tb_data_write_interface.sv
// Directed self-checking bench for data_write_interface: one DUT with misaligned
// splitting enabled and one with it disabled, sharing clock, reset and memory ready.
module tb_data_write_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        store_en, nf_store_en;
  logic [31:0] long_addr, store_value;
  logic [2:0]  store_type;
  logic        mem_ready;

  logic        store_stall, store_done, misaligned_fault, mem_write_req;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_byte_en;

  logic        nf_stall, nf_done, nf_fault, nf_req;
  logic [31:0] nf_addr, nf_data;
  logic [3:0]  nf_be;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_write_interface #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .store_en         (store_en),
    .long_addr        (long_addr),
    .store_value      (store_value),
    .store_type       (store_type),
    .store_stall      (store_stall),
    .store_done       (store_done),
    .misaligned_fault (misaligned_fault),
    .mem_write_req    (mem_write_req),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_byte_en      (mem_byte_en),
    .mem_ready        (mem_ready)
  );

  data_write_interface #(.ALLOW_MISALIGNED(1'b0)) dut_nf (
    .clk              (clk),
    .reset            (reset),
    .store_en         (nf_store_en),
    .long_addr        (long_addr),
    .store_value      (store_value),
    .store_type       (store_type),
    .store_stall      (nf_stall),
    .store_done       (nf_done),
    .misaligned_fault (nf_fault),
    .mem_write_req    (nf_req),
    .mem_addr         (nf_addr),
    .mem_write_data   (nf_data),
    .mem_byte_en      (nf_be),
    .mem_ready        (mem_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    store_en    = 1'b1;
    nf_store_en = 1'b1;
    mem_ready   = 1'b1;
    store_type  = 3'b100;
    long_addr   = 32'h0000_3001;
    store_value = 32'h1122_3344;
    step();
    step();
    checks++; if (mem_write_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%0b exp=0", mem_write_req); end
    checks++; if (store_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b exp=0", store_stall); end
    checks++; if (store_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b exp=0", store_done); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_write_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", mem_write_data); end
    checks++; if (mem_byte_en !== 4'b0) begin failures++; $display("[TB] FAIL reset_be got=%b exp=0000", mem_byte_en); end
    checks++; if (nf_fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_nf_fault got=%0b exp=0", nf_fault); end
    store_en    = 1'b0;
    nf_store_en = 1'b0;
    reset       = 1'b0;
    step();
    checks++; if (mem_write_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_req got=%0b exp=0", mem_write_req); end
  endtask

  task automatic test_byte();
    store_type  = 3'b001;
    long_addr   = 32'h0000_1003;
    store_value = 32'hAABB_CCDD;
    mem_ready   = 1'b1;
    store_en    = 1'b1;
    step();
    store_en = 1'b0;
    checks++; if (mem_write_req !== 1'b1) begin failures++; $display("[TB] FAIL byte_req got=%0b exp=1", mem_write_req); end
    checks++; if (mem_addr !== 32'h0000_1000) begin failures++; $display("[TB] FAIL byte_addr got=%h exp=00001000", mem_addr); end
    checks++; if (mem_byte_en !== 4'b1000) begin failures++; $display("[TB] FAIL byte_be got=%b exp=1000", mem_byte_en); end
    checks++; if (mem_write_data !== 32'hDD00_0000) begin failures++; $display("[TB] FAIL byte_data got=%h exp=dd000000", mem_write_data); end
    checks++; if (store_stall !== 1'b0) begin failures++; $display("[TB] FAIL byte_stall got=%0b exp=0", store_stall); end
    checks++; if (store_done !== 1'b0) begin failures++; $display("[TB] FAIL byte_done_early got=%0b exp=0", store_done); end
    step();
    checks++; if (store_done !== 1'b1) begin failures++; $display("[TB] FAIL byte_done got=%0b exp=1", store_done); end
    checks++; if (mem_write_req !== 1'b0) begin failures++; $display("[TB] FAIL byte_req_after got=%0b exp=0", mem_write_req); end
    step();
    checks++; if (store_done !== 1'b0) begin failures++; $display("[TB] FAIL byte_done_pulse got=%0b exp=0", store_done); end
  endtask

  task automatic test_hword();
    store_type  = 3'b010;
    long_addr   = 32'h0000_2006;
    store_value = 32'h0000_1234;
    store_en    = 1'b1;
    step();
    store_en = 1'b0;
    checks++; if (mem_addr !== 32'h0000_2004) begin failures++; $display("[TB] FAIL hword_addr got=%h exp=00002004", mem_addr); end
    checks++; if (mem_byte_en !== 4'b1100) begin failures++; $display("[TB] FAIL hword_be got=%b exp=1100", mem_byte_en); end
    checks++; if (mem_write_data !== 32'h1234_0000) begin failures++; $display("[TB] FAIL hword_data got=%h exp=12340000", mem_write_data); end
    step();
    checks++; if (store_done !== 1'b1) begin failures++; $display("[TB] FAIL hword_done got=%0b exp=1", store_done); end
  endtask

  task automatic test_word_split();
    store_type  = 3'b100;
    long_addr   = 32'h0000_3001;
    store_value = 32'h1122_3344;
    store_en    = 1'b1;
    step();
    store_en = 1'b0;
    checks++; if (mem_addr !== 32'h0000_3000) begin failures++; $display("[TB] FAIL split_b0_addr got=%h exp=00003000", mem_addr); end
    checks++; if (mem_byte_en !== 4'b1110) begin failures++; $display("[TB] FAIL split_b0_be got=%b exp=1110", mem_byte_en); end
    checks++; if (mem_write_data !== 32'h2233_4400) begin failures++; $display("[TB] FAIL split_b0_data got=%h exp=22334400", mem_write_data); end
    checks++; if (store_stall !== 1'b1) begin failures++; $display("[TB] FAIL split_b0_stall got=%0b exp=1", store_stall); end
    step();
    checks++; if (mem_write_req !== 1'b1) begin failures++; $display("[TB] FAIL split_b1_req got=%0b exp=1", mem_write_req); end
    checks++; if (mem_addr !== 32'h0000_3004) begin failures++; $display("[TB] FAIL split_b1_addr got=%h exp=00003004", mem_addr); end
    checks++; if (mem_byte_en !== 4'b0001) begin failures++; $display("[TB] FAIL split_b1_be got=%b exp=0001", mem_byte_en); end
    checks++; if (mem_write_data !== 32'h0000_0011) begin failures++; $display("[TB] FAIL split_b1_data got=%h exp=00000011", mem_write_data); end
    checks++; if (store_stall !== 1'b0) begin failures++; $display("[TB] FAIL split_b1_stall got=%0b exp=0", store_stall); end
    checks++; if (store_done !== 1'b0) begin failures++; $display("[TB] FAIL split_done_early got=%0b exp=0", store_done); end
    step();
    checks++; if (store_done !== 1'b1) begin failures++; $display("[TB] FAIL split_done got=%0b exp=1", store_done); end
    checks++; if (mem_write_req !== 1'b0) begin failures++; $display("[TB] FAIL split_req_after got=%0b exp=0", mem_write_req); end
  endtask

  task automatic test_hword_wrap();
    store_type  = 3'b010;
    long_addr   = 32'hFFFF_FFFF;
    store_value = 32'h0000_1234;
    store_en    = 1'b1;
    step();
    store_en = 1'b0;
    checks++; if (mem_addr !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_b0_addr got=%h exp=fffffffc", mem_addr); end
    checks++; if (mem_byte_en !== 4'b1000) begin failures++; $display("[TB] FAIL wrap_b0_be got=%b exp=1000", mem_byte_en); end
    checks++; if (mem_write_data !== 32'h3400_0000) begin failures++; $display("[TB] FAIL wrap_b0_data got=%h exp=34000000", mem_write_data); end
    step();
    checks++; if (mem_addr !== 32'h0000_0000) begin failures++; $display("[TB] FAIL wrap_b1_addr got=%h exp=00000000", mem_addr); end
    checks++; if (mem_byte_en !== 4'b0001) begin failures++; $display("[TB] FAIL wrap_b1_be got=%b exp=0001", mem_byte_en); end
    checks++; if (mem_write_data !== 32'h0000_0012) begin failures++; $display("[TB] FAIL wrap_b1_data got=%h exp=00000012", mem_write_data); end
    step();
    checks++; if (store_done !== 1'b1) begin failures++; $display("[TB] FAIL wrap_done got=%0b exp=1", store_done); end
  endtask

  task automatic test_wait_states();
    store_type  = 3'b100;
    long_addr   = 32'h0000_4000;
    store_value = 32'hCAFE_BABE;
    mem_ready   = 1'b0;
    store_en    = 1'b1;
    step();
    store_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_write_req !== 1'b1) begin failures++; $display("[TB] FAIL wait_req cyc=%0d got=%0b exp=1", i, mem_write_req); end
      checks++; if (mem_addr !== 32'h0000_4000) begin failures++; $display("[TB] FAIL wait_addr cyc=%0d got=%h exp=00004000", i, mem_addr); end
      checks++; if (mem_write_data !== 32'hCAFE_BABE) begin failures++; $display("[TB] FAIL wait_data cyc=%0d got=%h exp=cafebabe", i, mem_write_data); end
      checks++; if (mem_byte_en !== 4'b1111) begin failures++; $display("[TB] FAIL wait_be cyc=%0d got=%b exp=1111", i, mem_byte_en); end
      checks++; if (store_stall !== 1'b1) begin failures++; $display("[TB] FAIL wait_stall cyc=%0d got=%0b exp=1", i, store_stall); end
      checks++; if (store_done !== 1'b0) begin failures++; $display("[TB] FAIL wait_done cyc=%0d got=%0b exp=0", i, store_done); end
      step();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (store_stall !== 1'b0) begin failures++; $display("[TB] FAIL wait_stall_release got=%0b exp=0", store_stall); end
    checks++; if (mem_write_req !== 1'b1) begin failures++; $display("[TB] FAIL wait_req_hold got=%0b exp=1", mem_write_req); end
    step();
    checks++; if (store_done !== 1'b1) begin failures++; $display("[TB] FAIL wait_done_final got=%0b exp=1", store_done); end
  endtask

  task automatic test_back_to_back();
    store_type  = 3'b011;
    long_addr   = 32'h0000_5001;
    store_value = 32'h0000_00A5;
    store_en    = 1'b1;
    step();
    store_en = 1'b0;
    checks++; if (mem_byte_en !== 4'b0010) begin failures++; $display("[TB] FAIL b2b_prio_be got=%b exp=0010", mem_byte_en); end
    checks++; if (mem_write_data !== 32'h0000_A500) begin failures++; $display("[TB] FAIL b2b_prio_data got=%h exp=0000a500", mem_write_data); end
    step();
    checks++; if (store_done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_done got=%0b exp=1", store_done); end
    store_type  = 3'b000;
    long_addr   = 32'h0000_5008;
    store_value = 32'h89AB_CDEF;
    store_en    = 1'b1;
    step();
    store_en = 1'b0;
    checks++; if (mem_write_req !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_req got=%0b exp=1", mem_write_req); end
    checks++; if (mem_addr !== 32'h0000_5008) begin failures++; $display("[TB] FAIL b2b_second_addr got=%h exp=00005008", mem_addr); end
    checks++; if (mem_byte_en !== 4'b1111) begin failures++; $display("[TB] FAIL b2b_second_be got=%b exp=1111", mem_byte_en); end
    checks++; if (mem_write_data !== 32'h89AB_CDEF) begin failures++; $display("[TB] FAIL b2b_second_data got=%h exp=89abcdef", mem_write_data); end
    step();
    checks++; if (store_done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_done got=%0b exp=1", store_done); end
  endtask

  task automatic test_fault();
    store_type  = 3'b100;
    long_addr   = 32'h0000_3002;
    store_value = 32'h1122_3344;
    nf_store_en = 1'b1;
    step();
    nf_store_en = 1'b0;
    checks++; if (nf_fault !== 1'b1) begin failures++; $display("[TB] FAIL fault_pulse got=%0b exp=1", nf_fault); end
    checks++; if (nf_req !== 1'b0) begin failures++; $display("[TB] FAIL fault_req got=%0b exp=0", nf_req); end
    checks++; if (nf_stall !== 1'b0) begin failures++; $display("[TB] FAIL fault_stall got=%0b exp=0", nf_stall); end
    step();
    checks++; if (nf_fault !== 1'b0) begin failures++; $display("[TB] FAIL fault_pulse_end got=%0b exp=0", nf_fault); end
    checks++; if (nf_req !== 1'b0) begin failures++; $display("[TB] FAIL fault_req_later got=%0b exp=0", nf_req); end
    checks++; if (nf_done !== 1'b0) begin failures++; $display("[TB] FAIL fault_done got=%0b exp=0", nf_done); end
    store_type  = 3'b010;
    store_value = 32'h0000_BEEF;
    nf_store_en = 1'b1;
    step();
    nf_store_en = 1'b0;
    checks++; if (nf_req !== 1'b1) begin failures++; $display("[TB] FAIL nf_aligned_req got=%0b exp=1", nf_req); end
    checks++; if (nf_be !== 4'b1100) begin failures++; $display("[TB] FAIL nf_aligned_be got=%b exp=1100", nf_be); end
    checks++; if (nf_data !== 32'hBEEF_0000) begin failures++; $display("[TB] FAIL nf_aligned_data got=%h exp=beef0000", nf_data); end
    checks++; if (nf_fault !== 1'b0) begin failures++; $display("[TB] FAIL nf_aligned_fault got=%0b exp=0", nf_fault); end
    step();
    checks++; if (nf_done !== 1'b1) begin failures++; $display("[TB] FAIL nf_aligned_done got=%0b exp=1", nf_done); end
  endtask

  task automatic test_reset_mid();
    store_type  = 3'b100;
    long_addr   = 32'h0000_3001;
    store_value = 32'h1122_3344;
    mem_ready   = 1'b1;
    store_en    = 1'b1;
    step();
    store_en = 1'b0;
    step();
    checks++; if (mem_addr !== 32'h0000_3004) begin failures++; $display("[TB] FAIL rstmid_in_b1 got=%h exp=00003004", mem_addr); end
    reset = 1'b1;
    step();
    checks++; if (mem_write_req !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_req got=%0b exp=0", mem_write_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_write_data !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_data got=%h exp=0", mem_write_data); end
    checks++; if (mem_byte_en !== 4'b0) begin failures++; $display("[TB] FAIL rstmid_be got=%b exp=0000", mem_byte_en); end
    checks++; if (store_stall !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_stall got=%0b exp=0", store_stall); end
    checks++; if (store_done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%0b exp=0", store_done); end
    reset = 1'b0;
    step();
    checks++; if (mem_write_req !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle_req got=%0b exp=0", mem_write_req); end
    checks++; if (store_done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle_done got=%0b exp=0", store_done); end
  endtask

  initial begin
    reset       = 1'b1;
    store_en    = 1'b0;
    nf_store_en = 1'b0;
    long_addr   = '0;
    store_value = '0;
    store_type  = 3'b100;
    mem_ready   = 1'b0;
    test_reset();
    test_byte();
    test_hword();
    test_word_split();
    test_hword_wrap();
    test_wait_states();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
